// File: rtl/noc_router_rr_if.sv
// Handshake bundle for the 3-port (E/W/L) router. Stat counters exist only
// when NOC_ROUTER_STATS_EN is defined.
interface noc_router_rr_if #(parameter int WIDTH = 16);
  logic             in_valid_e, in_valid_w, in_valid_l;
  logic [WIDTH-1:0] in_data_e,  in_data_w,  in_data_l;
  logic             in_ready_e, in_ready_w, in_ready_l;
  logic             in_afull_e, in_afull_w, in_afull_l;
  logic             out_valid_e, out_valid_w, out_valid_l;
  logic [WIDTH-1:0] out_data_e,  out_data_w,  out_data_l;
  logic             out_ready_e, out_ready_w, out_ready_l;
`ifdef NOC_ROUTER_STATS_EN
  logic [31:0]      stat_cnt_e, stat_cnt_w, stat_cnt_l;
`endif

  modport master (
    output in_valid_e, in_valid_w, in_valid_l,
    output in_data_e,  in_data_w,  in_data_l,
    input  in_ready_e, in_ready_w, in_ready_l,
    input  in_afull_e, in_afull_w, in_afull_l,
    input  out_valid_e, out_valid_w, out_valid_l,
    input  out_data_e,  out_data_w,  out_data_l,
    output out_ready_e, out_ready_w, out_ready_l
`ifdef NOC_ROUTER_STATS_EN
    , input stat_cnt_e, stat_cnt_w, stat_cnt_l
`endif
  );

  modport slave (
    input  in_valid_e, in_valid_w, in_valid_l,
    input  in_data_e,  in_data_w,  in_data_l,
    output in_ready_e, in_ready_w, in_ready_l,
    output in_afull_e, in_afull_w, in_afull_l,
    output out_valid_e, out_valid_w, out_valid_l,
    output out_data_e,  out_data_w,  out_data_l,
    input  out_ready_e, out_ready_w, out_ready_l
`ifdef NOC_ROUTER_STATS_EN
    , output stat_cnt_e, stat_cnt_w, stat_cnt_l
`endif
  );
endinterface

// File: rtl/noc_router_rr.sv
// 3-port 1-D NoC router: per-input FWFT FIFO, XY route, round-robin per output,
// registered output stage. Define NOC_ROUTER_STATS_EN for per-output flit counters.
module noc_router_rr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             afull_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_C  = (PW+1)'(DEPTH);
  localparam logic [PW:0] AFULL_C = (PW+1)'(DEPTH-1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]      cnt_q, cnt_d;

  assign head_o  = mem_q[rp_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_C);
  assign afull_o = (cnt_q >= AFULL_C);

  always_comb begin
    wp_d  = push_i ? wp_q + 1'b1 : wp_q;
    rp_d  = pop_i  ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset: occupancy alone defines what is valid
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end
endmodule

module noc_router_rr #(
  parameter int                WIDTH    = 16,
  parameter int                DEPTH    = 32,
  parameter int                ADDR_W   = 2,
  parameter logic [ADDR_W-1:0] LOCAL_IP = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  noc_router_rr_if.slave bus
);
  localparam int NP = 3;  // port index: E=0, W=1, L=2

  logic [NP-1:0]             in_valid, in_ready, in_afull, out_ready;
  logic [NP-1:0]             fifo_full, fifo_empty, pop, discard;
  logic [NP-1:0][WIDTH-1:0]  in_data, head;
  logic [NP-1:0][NP-1:0]     req;   // req[input][output]
  logic [NP-1:0][NP-1:0]     gnt;   // gnt[output][input]
  logic [NP-1:0][1:0]        ptr_q, ptr_d;
  logic [NP-1:0]             ov_q, ov_d;
  logic [NP-1:0][WIDTH-1:0]  od_q, od_d;
  logic                      rdy_q;

  assign in_valid  = {bus.in_valid_l, bus.in_valid_w, bus.in_valid_e};
  assign in_data   = {bus.in_data_l,  bus.in_data_w,  bus.in_data_e};
  assign out_ready = {bus.out_ready_l, bus.out_ready_w, bus.out_ready_e};

  assign bus.in_ready_e  = in_ready[0];
  assign bus.in_ready_w  = in_ready[1];
  assign bus.in_ready_l  = in_ready[2];
  assign bus.in_afull_e  = in_afull[0];
  assign bus.in_afull_w  = in_afull[1];
  assign bus.in_afull_l  = in_afull[2];
  assign bus.out_valid_e = ov_q[0];
  assign bus.out_valid_w = ov_q[1];
  assign bus.out_valid_l = ov_q[2];
  assign bus.out_data_e  = od_q[0];
  assign bus.out_data_w  = od_q[1];
  assign bus.out_data_l  = od_q[2];

  // holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  for (genvar i = 0; i < NP; i++) begin : g_in
    assign in_ready[i] = rdy_q & ~fifo_full[i];
    noc_router_rr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (in_valid[i] & in_ready[i]),
      .din_i   (in_data[i]),
      .pop_i   (pop[i]),
      .head_o  (head[i]),
      .empty_o (fifo_empty[i]),
      .full_o  (fifo_full[i]),
      .afull_o (in_afull[i])
    );
  end

  // untagged heads are dropped in place; tagged heads request one output
  always_comb begin
    logic [ADDR_W-1:0] d;
    req     = '0;
    discard = '0;
    d       = '0;
    for (int i = 0; i < NP; i++) begin
      d = head[i][ADDR_W:1];
      if (!fifo_empty[i]) begin
        if (!head[i][0])          discard[i] = 1'b1;
        else if (d == LOCAL_IP)   req[i][2]  = 1'b1;
        else if (d > LOCAL_IP)    req[i][0]  = 1'b1;
        else                      req[i][1]  = 1'b1;
      end
    end
  end

  always_comb begin
    int   src;
    logic hit;
    gnt   = '0;
    ptr_d = ptr_q;
    ov_d  = ov_q;
    od_d  = od_q;
    src   = 0;
    hit   = 1'b0;
    for (int x = 0; x < NP; x++) begin
      hit = 1'b0;
      if (out_ready[x]) ov_d[x] = 1'b0;
      if (!ov_q[x] || out_ready[x]) begin
        for (int j = 0; j < NP; j++) begin
          src = (int'(ptr_q[x]) + j) % NP;
          if (!hit && req[src][x]) begin
            hit          = 1'b1;
            gnt[x][src]  = 1'b1;
            ov_d[x]      = 1'b1;
            od_d[x]      = head[src];
            ptr_d[x]     = 2'((src + 1) % NP);
          end
        end
      end
    end
  end

  always_comb begin
    pop = discard;
    for (int i = 0; i < NP; i++)
      for (int x = 0; x < NP; x++)
        pop[i] = pop[i] | gnt[x][i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      ov_q  <= '0;
      od_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
    end
  end

`ifdef NOC_ROUTER_STATS_EN
  logic [NP-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int x = 0; x < NP; x++)
      if (ov_q[x] && out_ready[x] && cnt_q[x] != 32'hFFFF_FFFF)
        cnt_d[x] = cnt_q[x] + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.stat_cnt_e = cnt_q[0];
  assign bus.stat_cnt_w = cnt_q[1];
  assign bus.stat_cnt_l = cnt_q[2];
`endif
endmodule
